// File: rtl/esp32_boot_sequencer.sv
// ESP32 EN / boot-strap sequencer arbitrating between the USB host (DTR/RTS) and internal reboot requests.
// Optional: define ESP32_POWERUP_RESET_EN to run one "reboot to run" sequence right after reset.
module esp32_boot_sequencer #(
   parameter int C_RESET_CYCLES      = 250000,
   parameter int C_STRAP_CYCLES      = 1250000,
   parameter int C_PROG_RELEASE_BITS = 26,
   parameter int C_SYNC_STAGES       = 2
) (
   input  logic       clk_25mhz,
   input  logic       reset,
   input  logic       ftdi_ndtr,
   input  logic       ftdi_nrts,
   input  logic       ftdi_txd,
   input  logic       esp_disable,
   input  logic       req_valid,
   input  logic       req_prog,
   output logic       req_ready,
   output logic       wifi_en,
   output logic       strap_oe,
   output logic       strap_gpio0,
   output logic [1:0] owner,
   output logic       done,
   output logic       aborted
);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_RST       = 3'd1;
   localparam logic [2:0] S_STRAP     = 3'd2;
   localparam logic [2:0] S_PROG_HOLD = 3'd3;
   localparam logic [2:0] S_HOST      = 3'd4;

   localparam int CNT_MAX = (C_RESET_CYCLES > C_STRAP_CYCLES) ? C_RESET_CYCLES : C_STRAP_CYCLES;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam int RW      = C_PROG_RELEASE_BITS + 1;
   localparam logic [CW-1:0] RST_LAST   = CW'(C_RESET_CYCLES - 1);
   localparam logic [CW-1:0] STRAP_LAST = CW'(C_STRAP_CYCLES - 1);
   localparam logic [CW-1:0] STRAP_FULL = CW'(C_STRAP_CYCLES);

`ifdef ESP32_POWERUP_RESET_EN
   localparam logic POWERUP_INIT = 1'b1;
`else
   localparam logic POWERUP_INIT = 1'b0;
`endif

   logic [C_SYNC_STAGES-1:0] ndtrSync_q, nrtsSync_q, txdSync_q;
   logic [1:0]    hostPrev_q;
   logic          txdPrev_q;
   logic [2:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [RW-1:0] rel_q, rel_d, relInc;
   logic          prog_q, prog_d;
   logic          powerUp_q, powerUp_d;
   logic          wifiEn_q, wifiEn_d, strapOe_q, strapOe_d, strapIo0_q, strapIo0_d;
   logic [1:0]    owner_q, owner_d;
   logic          done_q, aborted_q, doneEvt, abortEvt;
   logic [1:0]    hostD;
   logic          startEvent, activity, relExpired, reqReady;

   assign hostD      = {ndtrSync_q[C_SYNC_STAGES-1], nrtsSync_q[C_SYNC_STAGES-1]};
   assign startEvent = (hostD == 2'b10) && (hostPrev_q != 2'b10);
   assign activity   = startEvent
                     | ((txdSync_q[C_SYNC_STAGES-1] ^ txdPrev_q)
                        & ((state_q == S_HOST) | (state_q == S_PROG_HOLD)));
   assign relInc     = rel_q[RW-1] ? rel_q : rel_q + RW'(1);
   // Expiry looks at the incremented value so the release lands exactly 2^N cycles after the last clear.
   assign relExpired = relInc[RW-1] & ~activity;

   // Sequencing FSM; a host start event always wins over internal work.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      prog_d    = prog_q;
      powerUp_d = powerUp_q;
      doneEvt   = 1'b0;
      abortEvt  = 1'b0;
      reqReady  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (startEvent) begin
               state_d   = S_HOST;
               powerUp_d = 1'b0;
            end else if (powerUp_q) begin
               state_d   = S_RST;
               prog_d    = 1'b0;
               cnt_d     = '0;
               powerUp_d = 1'b0;
            end else if (req_valid) begin
               reqReady = 1'b1;
               state_d  = S_RST;
               prog_d   = req_prog;
               cnt_d    = '0;
            end
         end
         S_RST, S_STRAP, S_PROG_HOLD: begin
            if (startEvent) begin
               state_d  = S_HOST;
               doneEvt  = 1'b1;
               abortEvt = 1'b1;
            end else if (state_q == S_RST) begin
               if (cnt_q == RST_LAST) begin
                  state_d = S_STRAP;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end else if (state_q == S_STRAP) begin
               if (cnt_q == STRAP_LAST) begin
                  cnt_d = '0;
                  if (prog_q) begin
                     state_d = S_PROG_HOLD;
                  end else begin
                     state_d = S_IDLE;
                     doneEvt = 1'b1;
                  end
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end else begin
               if (cnt_q != STRAP_FULL) cnt_d = cnt_q + CW'(1);
               if (relExpired) begin
                  state_d = S_IDLE;
                  doneEvt = 1'b1;
               end
            end
         end
         S_HOST: begin
            if (relExpired) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (activity || ((state_d == S_HOST) && (state_q != S_HOST))
                   || ((state_d == S_PROG_HOLD) && (state_q != S_PROG_HOLD))) begin
         rel_d = '0;
      end else begin
         rel_d = relInc;
      end
   end

   // Pin values are decoded from the upcoming state so they register together with it.
   always_comb begin
      wifiEn_d   = 1'b1;
      strapOe_d  = 1'b1;
      strapIo0_d = 1'b1;
      owner_d    = 2'b10;
      case (state_d)
         S_RST: begin
            wifiEn_d   = 1'b0;
            strapIo0_d = ~prog_d;
         end
         S_STRAP:     strapIo0_d = ~prog_d;
         S_PROG_HOLD: strapIo0_d = (cnt_d == STRAP_FULL);
         S_HOST: begin
            owner_d    = 2'b01;
            wifiEn_d   = (hostD != 2'b10);
            strapIo0_d = (hostD != 2'b01);
         end
         default: begin
            strapOe_d = 1'b0;
            owner_d   = 2'b00;
         end
      endcase
   end

   always_ff @(posedge clk_25mhz or posedge reset) begin
      if (reset) begin
         ndtrSync_q <= '1;
         nrtsSync_q <= '1;
         txdSync_q  <= '1;
         hostPrev_q <= 2'b11;
         txdPrev_q  <= 1'b1;
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         rel_q      <= '0;
         prog_q     <= 1'b0;
         powerUp_q  <= POWERUP_INIT;
         wifiEn_q   <= 1'b1;
         strapOe_q  <= 1'b0;
         strapIo0_q <= 1'b1;
         owner_q    <= 2'b00;
         done_q     <= 1'b0;
         aborted_q  <= 1'b0;
      end else begin
         ndtrSync_q <= {ndtrSync_q[C_SYNC_STAGES-2:0], ftdi_ndtr};
         nrtsSync_q <= {nrtsSync_q[C_SYNC_STAGES-2:0], ftdi_nrts};
         txdSync_q  <= {txdSync_q[C_SYNC_STAGES-2:0], ftdi_txd};
         hostPrev_q <= hostD;
         txdPrev_q  <= txdSync_q[C_SYNC_STAGES-1];
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rel_q      <= rel_d;
         prog_q     <= prog_d;
         powerUp_q  <= powerUp_d;
         wifiEn_q   <= wifiEn_d;
         strapOe_q  <= strapOe_d;
         strapIo0_q <= strapIo0_d;
         owner_q    <= owner_d;
         done_q     <= doneEvt;
         aborted_q  <= abortEvt;
      end
   end

   // req_ready is combinational so a held request is taken on the very edge it is acknowledged.
   assign req_ready   = reqReady;
   assign wifi_en     = wifiEn_q & ~esp_disable;
   assign strap_oe    = strapOe_q;
   assign strap_gpio0 = strapIo0_q;
   assign owner       = owner_q;
   assign done        = done_q;
   assign aborted     = aborted_q;

endmodule

// File: tb/tb_esp32_boot_sequencer.sv
// Directed bench for esp32_boot_sequencer with short timers (reset 8, strap 4, release 2^6).
module tb_esp32_boot_sequencer;

   logic       clk_25mhz = 1'b0;
   logic       reset = 1'b0;
   logic       ftdi_ndtr = 1'b1, ftdi_nrts = 1'b1, ftdi_txd = 1'b1;
   logic       esp_disable = 1'b0, req_valid = 1'b0, req_prog = 1'b0;
   logic       req_ready, wifi_en, strap_oe, strap_gpio0, done, aborted;
   logic [1:0] owner;
   int         total = 0;
   int         bad = 0;

   esp32_boot_sequencer #(
      .C_RESET_CYCLES(8), .C_STRAP_CYCLES(4), .C_PROG_RELEASE_BITS(6), .C_SYNC_STAGES(2)
   ) dut (
      .clk_25mhz(clk_25mhz), .reset(reset), .ftdi_ndtr(ftdi_ndtr), .ftdi_nrts(ftdi_nrts),
      .ftdi_txd(ftdi_txd), .esp_disable(esp_disable), .req_valid(req_valid), .req_prog(req_prog),
      .req_ready(req_ready), .wifi_en(wifi_en), .strap_oe(strap_oe), .strap_gpio0(strap_gpio0),
      .owner(owner), .done(done), .aborted(aborted)
   );

   always #5 clk_25mhz = ~clk_25mhz;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      if (observed !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk_25mhz);
      #1;
   endtask

   task automatic applyStimulus(input logic ndtr, input logic nrts);
      ftdi_ndtr = ndtr;
      ftdi_nrts = nrts;
   endtask

   // Present a request in the current cycle; returns one cycle after the accepting edge.
   task automatic requestSequence(input logic prog);
      req_valid = 1'b1;
      req_prog  = prog;
      #1;
      checkOutput("req.ready", req_ready, 1);
      step(1);
      req_valid = 1'b0;
      checkOutput("req.readyAfter", req_ready, 0);
   endtask

   task automatic waitIdle();
      for (int i = 0; i < 300; i++) begin
         if (owner == 2'b00 && strap_oe == 1'b0) break;
         step(1);
      end
      checkOutput("waitIdle", {owner, strap_oe}, 0);
   endtask

   task automatic doReset();
      reset = 1'b1;
      step(3);
      reset = 1'b0;
`ifdef ESP32_POWERUP_RESET_EN
      for (int c = 1; c <= 13; c++) begin
         step(1);
         if (c <= 12) begin
            checkOutput("pwr.en", wifi_en, (c > 8));
            checkOutput("pwr.owner", owner, 2);
         end else begin
            checkOutput("pwr.done", done, 1);
            checkOutput("pwr.oe", strap_oe, 0);
         end
      end
      step(1);
`endif
   endtask

   initial begin
      // Reset state, with and without esp_disable
      #2 reset = 1'b1;
      esp_disable = 1'b1;
      #1;
      checkOutput("rst.enDisabled", wifi_en, 0);
      esp_disable = 1'b0;
      #1;
      checkOutput("rst.en", wifi_en, 1);
      checkOutput("rst.oe", strap_oe, 0);
      checkOutput("rst.io0", strap_gpio0, 1);
      checkOutput("rst.owner", owner, 0);
      checkOutput("rst.done", done, 0);
      checkOutput("rst.aborted", aborted, 0);
      checkOutput("rst.ready", req_ready, 0);
      doReset();

      // Reboot to run
      requestSequence(1'b0);
      for (int c = 1; c <= 12; c++) begin
         checkOutput("run.en", wifi_en, (c > 8));
         checkOutput("run.oe", strap_oe, 1);
         checkOutput("run.io0", strap_gpio0, 1);
         checkOutput("run.owner", owner, 2);
         checkOutput("run.done", done, 0);
         step(1);
      end
      checkOutput("run.endOe", strap_oe, 0);
      checkOutput("run.endDone", done, 1);
      checkOutput("run.endAborted", aborted, 0);
      checkOutput("run.endOwner", owner, 0);
      step(1);
      checkOutput("run.donePulse", done, 0);

      // Reboot to flash: PROG_HOLD starts at cycle 13 and releases after 64 cycles
      requestSequence(1'b1);
      for (int c = 1; c <= 76; c++) begin
         checkOutput("prog.en", wifi_en, (c > 8));
         checkOutput("prog.oe", strap_oe, 1);
         checkOutput("prog.io0", strap_gpio0, (c > 16));
         checkOutput("prog.owner", owner, 2);
         checkOutput("prog.done", done, 0);
         step(1);
      end
      checkOutput("prog.endOe", strap_oe, 0);
      checkOutput("prog.endDone", done, 1);
      checkOutput("prog.endAborted", aborted, 0);
      checkOutput("prog.endOwner", owner, 0);

      // Host auto-reset protocol, 3-cycle latency, txd activity keeps the straps
      step(3);
      applyStimulus(1'b1, 1'b0);
      step(2);
      checkOutput("host.ownerEarly", owner, 0);
      step(1);
      checkOutput("host.owner", owner, 1);
      checkOutput("host.en10", wifi_en, 0);
      checkOutput("host.io0_10", strap_gpio0, 1);
      checkOutput("host.oe", strap_oe, 1);
      step(4);
      applyStimulus(1'b0, 1'b1);
      step(2);
      checkOutput("host.enLatency", wifi_en, 0);
      step(1);
      checkOutput("host.en01", wifi_en, 1);
      checkOutput("host.io0_01", strap_gpio0, 0);
      step(4);
      applyStimulus(1'b1, 1'b1);
      step(3);
      checkOutput("host.en11", wifi_en, 1);
      checkOutput("host.io0_11", strap_gpio0, 1);
      for (int k = 0; k < 4; k++) begin
         step(40);
         checkOutput("host.holdOe", strap_oe, 1);
         ftdi_txd = ~ftdi_txd;
      end
      step(66);
      checkOutput("host.lastOe", strap_oe, 1);
      checkOutput("host.lastOwner", owner, 1);
      step(1);
      checkOutput("host.relOe", strap_oe, 0);
      checkOutput("host.relOwner", owner, 0);
      checkOutput("host.relDone", done, 0);

      // Preemption at cycle 3 of RST
      step(2);
      requestSequence(1'b0);
      applyStimulus(1'b1, 1'b0);
      step(2);
      checkOutput("pre.ownerRst", owner, 2);
      checkOutput("pre.enRst", wifi_en, 0);
      step(1);
      checkOutput("pre.owner", owner, 1);
      checkOutput("pre.done", done, 1);
      checkOutput("pre.aborted", aborted, 1);
      checkOutput("pre.en", wifi_en, 0);
      step(1);
      checkOutput("pre.donePulse", done, 0);
      applyStimulus(1'b1, 1'b1);
      waitIdle();

      // Simultaneous request and host start in IDLE
      step(2);
      applyStimulus(1'b1, 1'b0);
      step(2);
      req_valid = 1'b1;
      req_prog  = 1'b0;
      #1;
      checkOutput("tie.ready", req_ready, 0);
      step(1);
      checkOutput("tie.owner", owner, 1);
      checkOutput("tie.readyHost", req_ready, 0);
      req_valid = 1'b0;

      // esp_disable while the host drives d = 01
      applyStimulus(1'b0, 1'b1);
      step(3);
      checkOutput("dis.enBefore", wifi_en, 1);
      checkOutput("dis.io0Before", strap_gpio0, 0);
      esp_disable = 1'b1;
      #1;
      checkOutput("dis.en", wifi_en, 0);
      checkOutput("dis.io0", strap_gpio0, 0);
      checkOutput("dis.owner", owner, 1);
      step(2);
      checkOutput("dis.enHeld", wifi_en, 0);
      esp_disable = 1'b0;
      #1;
      checkOutput("dis.enAfter", wifi_en, 1);
      applyStimulus(1'b1, 1'b1);
      waitIdle();

      // Asynchronous reset in the middle of a sequence
      step(1);
      requestSequence(1'b1);
      step(3);
      checkOutput("mid.enBefore", wifi_en, 0);
      reset = 1'b1;
      #1;
      checkOutput("mid.en", wifi_en, 1);
      checkOutput("mid.owner", owner, 0);
      checkOutput("mid.oe", strap_oe, 0);
      checkOutput("mid.io0", strap_gpio0, 1);
      doReset();
      step(2);
      checkOutput("mid.idleOwner", owner, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
